// File: rtl/bchecc_enc_par.sv
// Systematic BCH encoder: streams a sector of DW-bit beats through, then appends PW parity bits as PW/DW beats.
// One registered output stage, one cycle per beat; dout_ready_i low freezes the output, the parity register and the counters.

function automatic logic [12:0] bch13_mul(input logic [12:0] a, input logic [12:0] b);
    logic [12:0] p;
    logic [12:0] s;
    p = '0;
    s = a;
    for (int i = 0; i < 13; i++) begin
        if (b[i]) p = p ^ s;
        s = s[12] ? ({s[11:0], 1'b0} ^ 13'h001B) : {s[11:0], 1'b0};
    end
    return p;
endfunction

// g(x) = product of the minimal polynomials of alpha^1,3,..,15 over GF(2^13), p(x) = x^13+x^4+x^3+x+1.
function automatic logic [103:0] bch13_t8_gen();
    logic [104:0]     g;
    logic [104:0]     acc;
    logic [14*13-1:0] m;
    logic [12:0]      root;
    logic [12:0]      c;
    g = 105'd1;
    for (int k = 1; k < 16; k = k + 2) begin
        root = 13'd1;
        for (int e = 0; e < k; e++) root = bch13_mul(root, 13'd2);
        m = '0;
        m[12:0] = 13'd1;
        for (int j = 0; j < 13; j++) begin
            for (int i = 13; i >= 0; i--) begin
                if (i > 0) c = m[(i-1)*13 +: 13];
                else       c = '0;
                m[i*13 +: 13] = c ^ bch13_mul(root, m[i*13 +: 13]);
            end
            root = bch13_mul(root, root);
        end
        acc = '0;
        for (int i = 0; i < 14; i++)
            if (m[i*13]) acc = acc ^ (g << i);
        g = acc;
    end
    return g[103:0];
endfunction

module bchecc_enc_par #(
    parameter int unsigned   DW  = 8,
    parameter int unsigned   PW  = 104,
    parameter logic [PW-1:0] GEN = PW'(bch13_t8_gen()),
    parameter int unsigned   LW  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic          abort_i,
    input  logic [DW-1:0] din_i,
    input  logic          din_valid_i,
    output logic          din_ready_o,
    output logic [DW-1:0] dout_o,
    output logic          dout_valid_o,
    input  logic          dout_ready_i,
    output logic          dout_last_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);
    localparam int unsigned NPB = PW / DW;
    localparam int unsigned PCW = $clog2(NPB + 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR, LAST} state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic [PW-1:0]  r_q, r_d;
    logic [DW-1:0]  dout_q, dout_d;
    logic           dout_valid_q, dout_valid_d;
    logic           dout_last_q, dout_last_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           out_free;
    logic           din_xfer;

    function automatic logic [PW-1:0] lfsr_step(input logic [PW-1:0] r, input logic [DW-1:0] d);
        logic [PW-1:0] x;
        logic          fb;
        x = r;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = d[i] ^ x[PW-1];
            x  = {x[PW-2:0], 1'b0} ^ (fb ? GEN : '0);
        end
        return x;
    endfunction

    assign out_free    = !dout_valid_q || dout_ready_i;
    // abort_i wins over a transfer, so never advertise ready while it is high
    assign din_ready_o = (state_q == DATA) && out_free && !abort_i;
    assign din_xfer    = din_valid_i && din_ready_o;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pcnt_d       = pcnt_q;
        r_d          = r_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !dout_ready_i;
        dout_last_d  = dout_last_q && !dout_ready_i;
        done_d       = 1'b0;
        err_d        = start_i && ((state_q != IDLE) || (len_i == '0));
        case (state_q)
            IDLE: begin
                if (start_i && (len_i != '0)) begin
                    cnt_d   = len_i;
                    r_d     = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (din_xfer) begin
                    dout_d       = din_i;
                    dout_valid_d = 1'b1;
                    cnt_d        = cnt_q - LW'(1);
                    r_d          = lfsr_step(r_q, din_i);
                    if (cnt_q == LW'(1)) begin
                        pcnt_d  = PCW'(NPB);
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                if (out_free) begin
                    dout_d       = r_q[PW-1 -: DW];
                    dout_valid_d = 1'b1;
                    r_d          = r_q << DW;
                    pcnt_d       = pcnt_q - PCW'(1);
                    if (pcnt_q == PCW'(1)) begin
                        dout_last_d = 1'b1;
                        state_d     = LAST;
                    end
                end
            end
            LAST: begin
                if (dout_valid_q && dout_ready_i && dout_last_q) begin
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i && (state_q != IDLE)) begin
            state_d      = IDLE;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            r_d          = '0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pcnt_q       <= '0;
            r_q          <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pcnt_q       <= pcnt_d;
            r_q          <= r_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign dout_last_o  = dout_last_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_bchecc_enc_par.sv
// Bench for bchecc_enc_par: a DW=8/PW=16/GEN=0x1021 instance against a polynomial long-division model,
// plus a default-parameter instance for the full-length streaming timing.
`timescale 1ns/1ps
module tb_bchecc_enc_par;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_a, abort_a, din_valid_a, din_ready_a, dout_valid_a, dout_ready_a;
    logic       dout_last_a, busy_a, done_a, err_a;
    logic [9:0] len_a;
    logic [7:0] din_a, dout_a;

    logic       start_b, abort_b, din_valid_b, din_ready_b, dout_valid_b, dout_ready_b;
    logic       dout_last_b, busy_b, done_b, err_b;
    logic [9:0] len_b;
    logic [7:0] din_b, dout_b;

    bchecc_enc_par #(.DW(8), .PW(16), .GEN(16'h1021), .LW(10)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .len_i(len_a), .abort_i(abort_a),
        .din_i(din_a), .din_valid_i(din_valid_a), .din_ready_o(din_ready_a),
        .dout_o(dout_a), .dout_valid_o(dout_valid_a), .dout_ready_i(dout_ready_a),
        .dout_last_o(dout_last_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    bchecc_enc_par u_dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .len_i(len_b), .abort_i(abort_b),
        .din_i(din_b), .din_valid_i(din_valid_b), .din_ready_o(din_ready_b),
        .dout_o(dout_b), .dout_valid_o(dout_valid_b), .dout_ready_i(dout_ready_b),
        .dout_last_o(dout_last_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    int         n_chk = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [8:0] exp_q[$];
    logic       hold_vld;
    logic [9:0] hold_val;
    bit         rr_en = 1'b0;
    logic [7:0] dbuf [0:15];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Parity as the remainder of M(x)*x^16 divided by x^16+0x1021, by textbook long division.
    function automatic logic [15:0] ref_par(input int len);
        logic        bits_q[$];
        logic [16:0] g;
        logic [15:0] rem;
        logic [7:0]  by;
        g = {1'b1, 16'h1021};
        for (int i = 0; i < len; i++) begin
            by = dbuf[i];
            for (int j = 7; j >= 0; j--) bits_q.push_back(by[j]);
        end
        for (int j = 0; j < 16; j++) bits_q.push_back(1'b0);
        for (int i = 0; i + 16 < bits_q.size(); i++)
            if (bits_q[i])
                for (int j = 0; j <= 16; j++) bits_q[i+j] = bits_q[i+j] ^ g[16-j];
        for (int j = 0; j < 16; j++) rem[15-j] = bits_q[bits_q.size() - 16 + j];
        return rem;
    endfunction

    // Output monitor for instance A: scoreboard pop, stall stability, pulse counting.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld)
                chk("stall_hold", 32'({dout_valid_a, dout_last_a, dout_a}), 32'(hold_val));
            if (dout_valid_a && dout_ready_a) begin
                if (exp_q.size() == 0) e = 10'h3FF;
                else                   e = {1'b0, exp_q.pop_front()};
                chk("beat", 32'({1'b0, dout_last_a, dout_a}), 32'(e));
            end
            hold_vld = dout_valid_a && !dout_ready_a;
            hold_val = {dout_valid_a, dout_last_a, dout_a};
            if (done_a) done_cnt++;
            if (err_a)  err_cnt++;
        end
    end

    initial begin
        dout_ready_a = 1'b1;
        forever begin
            @(posedge clk); #1;
            dout_ready_a = rr_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // mode 0: complete sector, 1: abort after first parity beat, 2: async reset after 4 data beats
    task automatic send_sector(input int len, input logic [15:0] par, input int mode, input int start_at);
        int i;
        int guard;
        int d0;
        bit xf;
        bit started;
        for (int k = 0; k < len; k++) exp_q.push_back({1'b0, dbuf[k]});
        exp_q.push_back({1'b0, par[15:8]});
        exp_q.push_back({1'b1, par[7:0]});
        d0 = done_cnt;
        @(posedge clk); #1;
        start_a = 1'b1;
        len_a   = 10'(len);
        @(posedge clk); #1;
        start_a     = 1'b0;
        i           = 0;
        guard       = 0;
        started     = 1'b0;
        din_a       = dbuf[0];
        din_valid_a = 1'b1;
        while (i < len && guard < 1000) begin
            @(negedge clk);
            xf = din_valid_a && din_ready_a;
            @(posedge clk); #1;
            guard++;
            start_a = 1'b0;
            if (xf) i++;
            if (mode == 2 && i == 4) begin
                #2 rst = 1'b1;
                #1;
                chk("rst_mid_vld", 32'(dout_valid_a), 32'(0));
                chk("rst_mid_busy", 32'(busy_a), 32'(0));
                chk("rst_mid_rdy", 32'(din_ready_a), 32'(0));
                chk("rst_mid_dout", 32'({dout_last_a, dout_a}), 32'(0));
                chk("rst_mid_pulses", 32'({done_a, err_a}), 32'(0));
                @(posedge clk); #1;
                rst         = 1'b0;
                din_valid_a = 1'b0;
                exp_q.delete();
                return;
            end
            if (i == start_at && !started) begin
                start_a = 1'b1;
                started = 1'b1;
            end
            din_valid_a = (i < len) && (!rr_en || ($urandom_range(0, 3) != 0));
            if (i < len) din_a = dbuf[i];
        end
        din_valid_a = 1'b0;
        chk("data_beats_sent", 32'(i), 32'(len));
        if (mode == 1) begin
            @(posedge clk); #1;
            abort_a = 1'b1;
            @(posedge clk); #1;
            abort_a = 1'b0;
            chk("abort_busy", 32'(busy_a), 32'(0));
            chk("abort_vld", 32'({dout_valid_a, dout_last_a}), 32'(0));
            exp_q.delete();
            repeat (4) @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done_cnt - d0), 32'(0));
            return;
        end
        guard = 0;
        while (done_cnt == d0 && guard < 400) begin
            @(posedge clk); #2;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt - d0), 32'(1));
        chk("beats_left", 32'(exp_q.size()), 32'(0));
        chk("idle_after", 32'(busy_a), 32'(0));
    endtask

    task automatic load_ascii();
        for (int k = 0; k < 9; k++) dbuf[k] = 8'(8'h31 + k);
    endtask

    initial begin
        int e0;
        int len;
        int nx, nb, nz, gap, first, done_at, last_at;
        rst = 1'b1;
        start_a = 1'b0; len_a = '0; abort_a = 1'b0; din_a = '0; din_valid_a = 1'b0;
        start_b = 1'b0; len_b = '0; abort_b = 1'b0; din_b = '0; din_valid_b = 1'b0;
        dout_ready_b = 1'b1;
        hold_vld = 1'b0;
        hold_val = '0;
        #2;
        chk("rst_vld_a", 32'({dout_valid_a, dout_last_a}), 32'(0));
        chk("rst_busy_a", 32'(busy_a), 32'(0));
        chk("rst_rdy_a", 32'(din_ready_a), 32'(0));
        chk("rst_dout_a", 32'(dout_a), 32'(0));
        chk("rst_pulses_a", 32'({done_a, err_a}), 32'(0));
        chk("rst_b", 32'({dout_valid_b, dout_last_b, busy_b, done_b, err_b, din_ready_b}), 32'(0));
        #20;
        @(posedge clk); #1;
        rst = 1'b0;

        // "123456789" with CRC-CCITT generator, full-rate then random backpressure
        load_ascii();
        send_sector(9, 16'h31C3, 0, -1);
        rr_en = 1'b1;
        send_sector(9, 16'h31C3, 0, -1);
        rr_en = 1'b0;

        // zero-length start and start while busy
        e0 = err_cnt;
        @(posedge clk); #1;
        start_a = 1'b1;
        len_a   = '0;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("len0_busy", 32'(busy_a), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("len0_err", 32'(err_cnt - e0), 32'(1));
        e0 = err_cnt;
        send_sector(9, 16'h31C3, 0, 5);
        chk("busy_start_err", 32'(err_cnt - e0), 32'(1));

        // abort in PAR, then a clean sector
        send_sector(9, 16'h31C3, 1, -1);
        send_sector(9, 16'h31C3, 0, -1);

        // async reset mid-DATA, then a clean sector
        send_sector(9, 16'h31C3, 2, -1);
        send_sector(9, 16'h31C3, 0, -1);

        // random sectors under random backpressure
        rr_en = 1'b1;
        for (int s = 0; s < 6; s++) begin
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) dbuf[k] = 8'($urandom);
            send_sector(len, ref_par(len), 0, -1);
        end
        rr_en = 1'b0;

        // default parameters: 512 zero beats streamed at full rate
        @(posedge clk); #1;
        start_b = 1'b1;
        len_b   = 10'd512;
        @(posedge clk); #1;
        start_b     = 1'b0;
        din_valid_b = 1'b1;
        nx = 0; nb = 0; nz = 0; gap = 0; first = -1; done_at = -1; last_at = -1;
        for (int c = 0; c < 700 && done_at < 0; c++) begin
            @(negedge clk);
            if (din_valid_b && din_ready_b) begin
                if (first < 0) first = c;
                nx++;
            end
            if (dout_valid_b) begin
                nb++;
                if (dout_b != 8'h00) nz++;
                if (dout_last_b) last_at = nb;
            end else if (nb > 0 && nb < 525) begin
                gap++;
            end
            if (done_b) done_at = c;
            @(posedge clk); #1;
            if (nx == 512) din_valid_b = 1'b0;
        end
        chk("def_data_xfers", 32'(nx), 32'(512));
        chk("def_out_beats", 32'(nb), 32'(525));
        chk("def_nonzero", 32'(nz), 32'(0));
        chk("def_last_pos", 32'(last_at), 32'(525));
        chk("def_bubbles", 32'(gap), 32'(0));
        chk("def_done_lat", 32'(done_at - first), 32'(526));
        chk("def_idle", 32'(busy_b), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bchecc_enc_par.md
Name: bchecc_enc_par

Overview:
Parametrised systematic BCH encoder for the NFC ECC path. It replaces the fixed 8-bit, fixed-t encoder with one that takes generic data width, parity length and generator polynomial, plus a runtime sector length. It streams a sector of data beats straight through with valid/ready handshakes and then appends the PW parity bits as PW/DW output beats. It sits between the NFC data mover and the flash write port.

Parameters:
- DW, 8: data beat width in bits. PW must be a multiple of DW.
- PW, 104: parity width in bits, equal to m*t (13*8 by default).
- GEN, t=8 BCH generator over GF(2^13) with p(x)=x^13+x^4+x^3+x+1: low PW coefficients of the monic generator g(x). Bit i is the coefficient of x^i; x^PW is implied.
- LW, 10: width of the sector length field, in beats.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous active-high reset.
- start_i, input, 1: single-cycle pulse that begins a sector.
- len_i, input, LW: sector data length in beats; sampled on start_i.
- abort_i, input, 1: abandons the current sector.
- din_i, input, DW: data beat. din_i[DW-1] is the first (highest-degree) bit.
- din_valid_i, input, 1: data beat valid.
- din_ready_o, output, 1: encoder can accept a data beat.
- dout_o, output, DW: output beat (data, then parity).
- dout_valid_o, output, 1: output beat valid.
- dout_ready_i, input, 1: downstream accepts the output beat.
- dout_last_o, output, 1: marks the final parity beat.
- busy_o, output, 1: high in any state except IDLE.
- done_o, output, 1: one-cycle pulse when the last beat is accepted downstream.
- err_o, output, 1: one-cycle pulse on an illegal start.

Behaviour:
- Reset:
  - All outputs are 0. State is IDLE, the parity register r[PW-1:0] is 0, and the beat counter is 0.
  - Reset asserted mid-sector discards the sector immediately. No done_o is produced.
- Output register:
  - The output is a single registered stage. It is "free" when !dout_valid_o or dout_ready_i.
  - dout_valid_o holds, and dout_o/dout_last_o stay stable, until accepted.
- States: IDLE, DATA, PAR, LAST.
- IDLE:
  - start_i with len_i != 0: latch len_i into cnt, clear r, go to DATA.
  - start_i with len_i == 0: stay in IDLE and pulse err_o.
- DATA:
  - din_ready_o = output free.
  - On a transfer (din_valid_i & din_ready_o):
    - dout_o <= din_i and dout_valid_o <= 1.
    - cnt decrements.
    - r is updated DW bits per cycle, MSB first. For each bit b: fb = b ^ r[PW-1]; r = {r[PW-2:0],1'b0} ^ (fb ? GEN : 0).
  - On the transfer where cnt==1: go to PAR with pcnt = PW/DW.
- PAR:
  - din_ready_o = 0.
  - Each cycle the output is free: dout_o <= r[PW-1 -: DW], r <<= DW, and pcnt decrements.
  - When pcnt==1, also set dout_last_o and go to LAST.
- LAST:
  - Wait until dout_valid_o & dout_ready_i & dout_last_o.
  - That cycle: clear dout_valid_o and dout_last_o, pulse done_o, go to IDLE.
  - In LAST, a start_i in the same cycle as the final acceptance is treated as busy.
- Latency and throughput:
  - Each beat appears on dout one cycle after acceptance.
  - The first parity beat is loaded in the cycle after the final data transfer, if the output is free.
  - Full throughput is one beat per cycle with no bubble between data and parity.
- start_i while busy_o: ignored, err_o pulses, and the current sector continues.
- abort_i:
  - In any non-IDLE state, next edge: state to IDLE, dout_valid_o/dout_last_o to 0, r cleared. No done_o.
  - abort_i outranks start_i and data transfers in the same cycle.
- Backpressure: dout_ready_i low freezes the output. r and cnt do not advance.
- din_valid_i in IDLE, PAR or LAST is ignored, since din_ready_o = 0.

Test Plan:
1. Instance DW=8, PW=16, GEN=16'h1021, start with len=9 and data "123456789" (8'h31..8'h39) -> dout gives the 9 data beats, then 8'h31, 8'h C3 (last=1); done_o pulses once.
2. Default parameters, len=512, all-zero data, dout_ready_i tied 1 -> 512 zero data beats then 13 zero parity beats on consecutive cycles. done_o fires 526 cycles after the first transfer, with no bubble between data and parity.
3. Same as test 1, but dout_ready_i toggles pseudo-randomly -> identical beat sequence; dout_o is stable whenever valid & !ready; parity is still 16'h31C3.
4. start_i with len_i=0 -> err_o pulses for one cycle, busy_o stays 0, no output beats. A start_i during beat 5 of a sector -> err_o pulses and the sector completes unchanged.
5. abort_i asserted in PAR after 1 parity beat -> next cycle busy_o=0 and dout_valid_o=0, no done_o; a fresh start (test 1 data) then yields parity 16'h31C3.
6. rst pulsed asynchronously mid-DATA -> all outputs 0 immediately; after release, test 1 passes.
